// File: rtl/clocks_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package clocks_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam int RELOCK_W   = 8;
    localparam int SYNC_DEPTH = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clocks_sync.sv
// Multi-flop single-bit synchronizer; q lags d by DEPTH clock cycles.
module clocks_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage_reg;
    logic [DEPTH-1:0] stage_next;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_next[gi] = d;
            end else begin : g_rest
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/clocks_lock_supervisor.sv
// PLL reset/lock supervisor: pulses the PLL reset, waits for a stable lock, then releases sys_rst.
// Optional macro CLOCKS_AUTO_RELOCK_EN: lock loss in RUN retries the PLL instead of latching FAULT.
module clocks_lock_supervisor
    import clocks_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                locked_async,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                lock_ok,
    output logic [RELOCK_W-1:0] relock_count,
    output logic                timeout_err
);

    localparam int TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);

    logic                locked_s;
    state_t              state_reg, state_next;
    logic [TW-1:0]       timer_reg, timer_next;
    logic                timeout_set;
    logic                relock_inc;
    logic                pll_rst_reg, sys_rst_reg, lock_ok_reg, timeout_err_reg;
    logic [RELOCK_W-1:0] relock_count_reg;

    clocks_sync #(.DEPTH(SYNC_DEPTH)) u_sync (
        .clk  (refclk),
        .srst (rst),
        .d    (locked_async),
        .q    (locked_s)
    );

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg + TW'(1);
        timeout_set = 1'b0;
        relock_inc  = 1'b0;
        case (state_reg)
            RESET_PLL: begin
                if (timer_reg == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABLE;
                    timer_next = '0;
                end else if (timer_reg == LOCK_LAST) begin
                    timeout_set = 1'b1;
                    state_next  = RESET_PLL;
                    timer_next  = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else if (timer_reg == STABLE_LAST) begin
                    state_next = RUN;
                    timer_next = '0;
                end
            end
            RUN: begin
                timer_next = '0;
                if (!locked_s) begin
                    relock_inc = 1'b1;
`ifdef CLOCKS_AUTO_RELOCK_EN
                    state_next = RESET_PLL;
`else
                    state_next = FAULT;
`endif
                end
            end
            FAULT: begin
                timer_next = '0;
            end
            default: begin
                state_next = RESET_PLL;
                timer_next = '0;
            end
        endcase
    end

    // Outputs are registered from state_next so they line up with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg        <= RESET_PLL;
            timer_reg        <= '0;
            pll_rst_reg      <= 1'b1;
            sys_rst_reg      <= 1'b1;
            lock_ok_reg      <= 1'b0;
            relock_count_reg <= '0;
            timeout_err_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            pll_rst_reg <= (state_next == RESET_PLL);
            sys_rst_reg <= (state_next != RUN);
            lock_ok_reg <= (state_next == RUN);
            if (relock_inc && (relock_count_reg != {RELOCK_W{1'b1}})) begin
                relock_count_reg <= relock_count_reg + RELOCK_W'(1);
            end
            if (timeout_set) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign pll_rst      = pll_rst_reg;
    assign sys_rst      = sys_rst_reg;
    assign lock_ok      = lock_ok_reg;
    assign relock_count = relock_count_reg;
    assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_clocks_lock_supervisor.sv
// Scoreboard bench for clocks_lock_supervisor: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_clocks_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked_async;
    logic       pll_rst, sys_rst, lock_ok, timeout_err;
    logic [7:0] relock_count;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [11:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [11:0] got;

    clocks_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8)
    ) dut (
        .refclk       (refclk),
        .rst          (rst),
        .locked_async (locked_async),
        .pll_rst      (pll_rst),
        .sys_rst      (sys_rst),
        .lock_ok      (lock_ok),
        .relock_count (relock_count),
        .timeout_err  (timeout_err)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc = cyc + 1;

    // Expected vector layout: {pll_rst, sys_rst, lock_ok, relock_count[7:0], timeout_err}
    task automatic expect_at(input int c, input string n, input logic p, input logic s,
                             input logic o, input logic [7:0] rc, input logic te);
        exp_t e;
        e.cyc  = c;
        e.name = n;
        e.exp  = {p, s, o, rc, te};
        sb.push_back(e);
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    always @(negedge refclk) begin
        got = {pll_rst, sys_rst, lock_ok, relock_count, timeout_err};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e   = sb.pop_front();
            n_tests = n_tests + 1;
            if (mon_e.cyc < cyc) begin
                n_fail = n_fail + 1;
                $display("[TB] FAIL %s: check for cycle %0d not reached in time (now %0d)",
                         mon_e.name, mon_e.cyc, cyc);
            end else if (got !== mon_e.exp) begin
                n_fail = n_fail + 1;
                $display("[TB] FAIL %s @%0d: got pll=%b sys=%b ok=%b rc=%0d te=%b, expected pll=%b sys=%b ok=%b rc=%0d te=%b",
                         mon_e.name, cyc, got[11], got[10], got[9], got[8:1], got[0],
                         mon_e.exp[11], mon_e.exp[10], mon_e.exp[9], mon_e.exp[8:1], mon_e.exp[0]);
            end else begin
                $display("[TB] ok   %s @%0d: pll=%b sys=%b ok=%b rc=%0d te=%b",
                         mon_e.name, cyc, got[11], got[10], got[9], got[8:1], got[0]);
            end
        end
    end

    initial begin
        int r;
        int c;
        int lvl;
        rst          = 1'b1;
        locked_async = 1'b1;

        // Power-up with lock present: PLL reset 4 cycles, 8 stable cycles, release.
        expect_at(1,  "reset_state",   1, 1, 0, 8'd0, 0);
        expect_at(5,  "a_pll_last",    1, 1, 0, 8'd0, 0);
        expect_at(6,  "a_pll_off",     0, 1, 0, 8'd0, 0);
        expect_at(14, "a_stable_last", 0, 1, 0, 8'd0, 0);
        expect_at(15, "a_run",         0, 0, 1, 8'd0, 0);
        goto(2);
        rst = 1'b0;

        // No lock at all: 20-cycle timeouts, PLL reset re-pulses each retry.
        goto(20);
        rst          = 1'b1;
        locked_async = 1'b0;
        r = 21;
        expect_at(r,      "b_reset",        1, 1, 0, 8'd0, 0);
        expect_at(r + 23, "b_wait_last",    0, 1, 0, 8'd0, 0);
        expect_at(r + 24, "b_timeout1",     1, 1, 0, 8'd0, 1);
        expect_at(r + 27, "b_retry1_last",  1, 1, 0, 8'd0, 1);
        expect_at(r + 28, "b_retry1_wait",  0, 1, 0, 8'd0, 1);
        expect_at(r + 48, "b_timeout2",     1, 1, 0, 8'd0, 1);
        expect_at(r + 52, "b_retry2_wait",  0, 1, 0, 8'd0, 1);
        goto(r);
        rst = 1'b0;
        goto(r + 100);

        // One-cycle glitch at stable count 5 restarts the full stable count.
        rst          = 1'b1;
        locked_async = 1'b1;
        r = cyc + 1;
        expect_at(r,      "c_reset_clears_te", 1, 1, 0, 8'd0, 0);
        expect_at(r + 11, "c_back_to_wait",    0, 1, 0, 8'd0, 0);
        expect_at(r + 13, "c_no_early_run",    0, 1, 0, 8'd0, 0);
        expect_at(r + 19, "c_stable_last",     0, 1, 0, 8'd0, 0);
        expect_at(r + 20, "c_run",             0, 0, 1, 8'd0, 0);
        goto(r);
        rst = 1'b0;
        goto(r + 8);
        locked_async = 1'b0;
        goto(r + 9);
        locked_async = 1'b1;

`ifdef CLOCKS_AUTO_RELOCK_EN
        // Repeated lock losses in RUN: automatic recovery, counter saturates at 255.
        c = r + 23;
        for (int i = 1; i <= 256; i++) begin
            goto(c);
            lvl = (i > 255) ? 255 : i;
            if (i <= 3) begin
                expect_at(c + 3,  $sformatf("d_loss%0d_reset", i),  1, 1, 0, 8'(lvl), 0);
                expect_at(c + 15, $sformatf("d_loss%0d_stable", i), 0, 1, 0, 8'(lvl), 0);
                expect_at(c + 16, $sformatf("d_loss%0d_run", i),    0, 0, 1, 8'(lvl), 0);
            end else if (i >= 255) begin
                expect_at(c + 3,  $sformatf("e_loss%0d_sat", i),    1, 1, 0, 8'(lvl), 0);
            end
            if (i == 256) begin
                expect_at(c + 10, "e_mid_stable",      0, 1, 0, 8'd255, 0);
                expect_at(c + 11, "e_rst_mid_stable",  1, 1, 0, 8'd0,   0);
            end
            locked_async = 1'b0;
            goto(c + 1);
            locked_async = 1'b1;
            if (i == 256) begin
                goto(c + 10);
                rst = 1'b1;
                goto(c + 11);
                rst = 1'b0;
            end
            c = c + 20;
        end
`else
        // Lock loss in RUN latches FAULT until rst; further losses are not counted.
        c = r + 23;
        goto(c);
        expect_at(c + 2,  "d_still_run",   0, 0, 1, 8'd0, 0);
        expect_at(c + 3,  "d_fault",       0, 1, 0, 8'd1, 0);
        expect_at(c + 12, "d_fault_holds", 0, 1, 0, 8'd1, 0);
        locked_async = 1'b0;
        goto(c + 1);
        locked_async = 1'b1;
        goto(c + 6);
        locked_async = 1'b0;
        goto(c + 7);
        locked_async = 1'b1;
        goto(c + 20);

        // Leave FAULT via rst, then assert rst again mid-STABLE.
        rst = 1'b1;
        r = cyc + 1;
        expect_at(r,     "e_fault_reset",    1, 1, 0, 8'd0, 0);
        expect_at(r + 7, "e_mid_stable",     0, 1, 0, 8'd0, 0);
        expect_at(r + 8, "e_rst_mid_stable", 1, 1, 0, 8'd0, 0);
        goto(r);
        rst = 1'b0;
        goto(r + 7);
        rst = 1'b1;
        goto(r + 8);
        rst = 1'b0;
`endif

        for (int k = 0; k < 64 && sb.size() > 0; k++) @(negedge refclk);
        while (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            n_tests = n_tests + 1;
            n_fail  = n_fail + 1;
            $display("[TB] FAIL %s: check for cycle %0d never evaluated", mon_e.name, mon_e.cyc);
        end
        @(negedge refclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
